// File: rtl/store_uart_monitor_pkg.sv
// Shared constants and the UART byte-shifter state encoding for the store trace monitor.
package store_mon_pkg;

  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam int         FRAME_BYTES = 7;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

endpackage

// File: rtl/store_uart_monitor_uart_tx_byte.sv
// 8N1 byte shifter. A new byte may be accepted on the last cycle of a stop bit,
// so bytes inside a frame run back to back. tx is registered one cycle behind the state.
module uart_tx_byte
  import store_mon_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       ready,
  output logic       idle,
  output logic       tx
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  tx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          bit_end;

  assign bit_end = (cnt_q == CW'(CLKS_PER_BIT - 1));
  assign ready   = (state_q == IDLE) || ((state_q == STOP) && bit_end);
  assign idle    = (state_q == IDLE);
  assign tx      = tx_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          shift_d = data;
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        tx_d = shift_q[0];
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (start) begin
            shift_d = data;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

endmodule

// File: rtl/store_uart_monitor.sv
// Captures flagged CPU stores into a FIFO and streams each {addr,data} pair
// as a 7-byte A5-led UART frame on tx.
module store_uart_monitor
  import store_mon_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [15:0]                   addressSal,
  input  logic [31:0]                   sal,
  output logic                          tx,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [47:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [2:0]    idx_q, idx_d;
  logic [47:0]   frame_q, frame_d;
  logic          full, push, pop, start, ready, idle;
  logic [7:0]    tx_byte;

  function automatic logic [7:0] frame_byte(input logic [47:0] f, input logic [2:0] i);
    case (i)
      3'd1:    return f[47:40];
      3'd2:    return f[39:32];
      3'd3:    return f[31:24];
      3'd4:    return f[23:16];
      3'd5:    return f[15:8];
      default: return f[7:0];
    endcase
  endfunction

  // idx_q == 0 means no frame in progress; otherwise it names the next byte to hand over.
  always_comb begin
    full     = (count_q == CW'(FIFO_DEPTH));
    pop      = idle && (idx_q == 3'd0) && (count_q != '0);
    push     = wr_en && (!full || pop);
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    ovf_d    = ovf_q || (wr_en && full && !pop);
    frame_d  = frame_q;
    idx_d    = idx_q;
    start    = 1'b0;
    tx_byte  = SYNC_BYTE;
    if (pop) begin
      frame_d = mem_q[rd_ptr_q];
      start   = 1'b1;
      idx_d   = 3'd1;
    end else if (ready && (idx_q != 3'd0)) begin
      start   = 1'b1;
      tx_byte = frame_byte(frame_q, idx_q);
      idx_d   = (idx_q == 3'(FRAME_BYTES - 1)) ? 3'd0 : idx_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      idx_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      idx_q    <= idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {addressSal, sal};
    frame_q <= frame_d;
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .data (tx_byte),
    .ready(ready),
    .idle (idle),
    .tx   (tx)
  );

  assign busy       = !idle || (count_q != '0);
  assign overflow   = ovf_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_store_uart_monitor.sv
// Randomized bench for store_uart_monitor; a frame-level reference model predicts
// tx bit by bit along with fifo_count, busy and overflow on every cycle.
module tb_store_uart_monitor;

  localparam int CPB       = 4;
  localparam int DEPTH     = 8;
  localparam int FRAME_CYC = 70 * CPB;

  logic        clk = 1'b0;
  logic        rst_n, wr_en;
  logic [15:0] addr;
  logic [31:0] data;
  logic        tx, busy, overflow;
  logic [3:0]  fifo_count;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [47:0] mq[$];
  logic [47:0] cur_frame = '0;
  bit          ovf = 1'b0;
  int          e = 0;
  int          frame_p = -100000;
  int          busy_until = -100000;

  always #5 clk = ~clk;

  store_uart_monitor #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .addressSal(addr),
    .sal       (data),
    .tx        (tx),
    .busy      (busy),
    .overflow  (overflow),
    .fifo_count(fifo_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", tag, e, obs, expv);
    end
  endtask

  function automatic logic exp_tx();
    int t, bitn, byten, b;
    logic [7:0] by;
    t = e - (frame_p + 1);
    if (t < 0 || t >= FRAME_CYC) return 1'b1;
    bitn  = t / CPB;
    byten = bitn / 10;
    b     = bitn % 10;
    by    = (byten == 0) ? 8'hA5 : 8'((cur_frame >> (8 * (6 - byten))) & 48'hFF);
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return by[b-1];
  endfunction

  task automatic model_edge();
    int  pre;
    bit  pop, full;
    e++;
    if (!rst_n) begin
      mq.delete();
      ovf        = 1'b0;
      frame_p    = -100000;
      busy_until = -100000;
    end else begin
      pre  = mq.size();
      full = (pre == DEPTH);
      pop  = (pre > 0) && (e > busy_until);
      if (pop) begin
        cur_frame  = mq.pop_front();
        frame_p    = e;
        busy_until = e + FRAME_CYC;
      end
      if (wr_en) begin
        if (!full || pop) mq.push_back({addr, data});
        else ovf = 1'b1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("fifo_count", fifo_count, mq.size());
    chk("overflow", overflow, ovf);
    chk("busy", busy, (mq.size() != 0) || (e < busy_until));
    chk("tx", tx, exp_tx());
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      wr_en = 1'b0;
      addr  = 16'($urandom);
      data  = $urandom;
      step();
    end
  endtask

  task automatic store(input logic [15:0] a, input logic [31:0] d);
    wr_en = 1'b1;
    addr  = a;
    data  = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    wr_en = 1'b0;
    repeat (n) step();
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while (!(mq.size() == 0 && e > busy_until + 1) && n < 5000) begin
      idle(1);
      n++;
    end
    if (n >= 5000) chk("drain_timeout", 1, 0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    wr_en = 1'b0;
    addr  = '0;
    data  = '0;

    // reset hold
    do_reset(3);
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_count", fifo_count, 0);
    idle(3);

    // single store
    store(16'h0010, 32'hDEADBEEF);
    idle(1);
    chk("single_tx_before_fall", tx, 1'b1);
    idle(1);
    chk("single_tx_fall", tx, 1'b0);
    drain();
    chk("single_busy_after", busy, 1'b0);

    // burst of 9
    for (int i = 0; i < 9; i++) store(16'($urandom), $urandom);
    chk("burst_peak", fifo_count, 8);
    chk("burst_ovf", overflow, 1'b0);
    drain();

    // overflow with data 0..9
    for (int i = 0; i < 10; i++) store(16'($urandom), 32'(i));
    chk("ovf_set", overflow, 1'b1);
    drain();
    chk("ovf_sticky", overflow, 1'b1);
    do_reset(1);
    chk("ovf_cleared", overflow, 1'b0);

    // full FIFO with push landing on the pop edge
    for (int i = 0; i < 9; i++) store(16'($urandom), $urandom);
    n = 0;
    while (e + 1 <= busy_until && n < 1000) begin
      idle(1);
      n++;
    end
    if (n >= 1000) chk("full_pop_timeout", 1, 0);
    store(16'hBEEF, 32'h12345678);
    chk("full_pop_count", fifo_count, 8);
    chk("full_pop_ovf", overflow, 1'b0);
    drain();

    // reset in the middle of the third byte
    for (int i = 0; i < 3; i++) store(16'($urandom), $urandom);
    n = 0;
    while ((e - frame_p - 1) != 20 * CPB + 8 && n < 1000) begin
      idle(1);
      n++;
    end
    if (n >= 1000) chk("midrst_timeout", 1, 0);
    do_reset(1);
    chk("midrst_tx", tx, 1'b1);
    chk("midrst_count", fifo_count, 0);
    idle(300);
    store(16'h1234, 32'hCAFEF00D);
    drain();

    // random traffic at several store densities
    for (int seg = 0; seg < 4; seg++) begin
      int pct;
      pct = (seg == 0) ? 1 : (seg == 1) ? 3 : (seg == 2) ? 10 : 50;
      for (int c = 0; c < 2500; c++) begin
        wr_en = ($urandom_range(0, 99) < pct);
        addr  = 16'($urandom);
        data  = $urandom;
        step();
      end
      wr_en = 1'b0;
      drain();
      do_reset(2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
